// File: rtl/shot_sequencer.sv
// Game-flow controller for the projectile display datapath: one-hot state
// strobes, animation step tick, hit/miss judgement and per-round shot limit.
//
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   start, fire           - single-cycle debounced button pulses
//   vX, vY                - player velocity entry, latched on fire
//   projectileCenterX/Y   - projectile position from the datapath
//   targetCenterX         - target position from the datapath
//   q_I .. q_Done         - one-hot state strobes
//   step                  - one-cycle animation step pulse (ANIMATE only)
//   vX_lat, vY_lat        - velocity captured at fire
//   hit                   - shot result, valid in DONE
//   shots_used            - shots fired this round
module shot_sequencer #(
    parameter int TICK_DIV    = 10_000_000,
    parameter int GROUND_Y    = 475,
    parameter int X_MAX       = 774,
    parameter int TARGET_HALF = 10,
    parameter int MAX_STEPS   = 255,
    parameter int MAX_SHOTS   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       fire,
    input  logic [3:0] vX,
    input  logic [3:0] vY,
    input  logic [9:0] projectileCenterX,
    input  logic [9:0] projectileCenterY,
    input  logic [9:0] targetCenterX,
    output logic       q_I,
    output logic       q_P1Shoot,
    output logic       q_Animate,
    output logic       q_Done,
    output logic       step,
    output logic [3:0] vX_lat,
    output logic [3:0] vY_lat,
    output logic       hit,
    output logic [2:0] shots_used
);

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [10:0] Y_LO  = 11'(GROUND_Y - 2);
    localparam logic [10:0] Y_HI  = 11'd900;
    localparam logic [10:0] X_LIM = 11'(X_MAX);
    localparam logic [10:0] HALF  = 11'(TARGET_HALF);
    localparam logic [10:0] REACH = 11'(TARGET_HALF + 5);
    localparam logic [7:0]  STEP_LIM = 8'(MAX_STEPS);
    localparam logic [2:0]  SHOT_LIM = 3'(MAX_SHOTS);

    typedef enum logic [1:0] {
        S_INIT,
        S_SHOOT,
        S_ANIMATE,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic          step_q, step_d;
    logic          eval_q, eval_d;
    logic [7:0]    steps_q, steps_d;
    logic [2:0]    shots_q, shots_d;
    logic          hit_q, hit_d;
    logic [3:0]    vx_q, vx_d;
    logic [3:0]    vy_q, vy_d;

    // Coordinates widened to 11 bits so target +/- reach never wraps.
    logic [10:0] px, py, tx;
    logic        landed, on_target, off_field, timed_out, evaluate;

    always_comb begin
        px        = {1'b0, projectileCenterX};
        py        = {1'b0, projectileCenterY};
        tx        = {1'b0, targetCenterX};
        // Y above 900 is a wrap above the top of the screen, still flying.
        landed    = (py >= Y_LO) && (py <= Y_HI);
        on_target = (px + REACH >= tx) && (px <= tx + HALF);
        off_field = px > X_LIM;
        timed_out = steps_q == STEP_LIM;
        // eval_q marks the cycle after a step, once the datapath has moved.
        evaluate  = eval_q && (steps_q >= 8'd2);
    end

    always_comb begin
        state_d = state_q;
        tick_d  = '0;
        step_d  = 1'b0;
        eval_d  = 1'b0;
        steps_d = steps_q;
        shots_d = shots_q;
        hit_d   = hit_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        unique case (state_q)
            S_INIT: begin
                if (start) begin
                    state_d = S_SHOOT;
                    shots_d = '0;
                    hit_d   = 1'b0;
                end
            end
            S_SHOOT: begin
                if (fire) begin
                    state_d = S_ANIMATE;
                    vx_d    = vX;
                    vy_d    = vY;
                    steps_d = '0;
                    if (shots_q != 3'd7) shots_d = shots_q + 3'd1;
                end
            end
            S_ANIMATE: begin
                tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + TW'(1);
                // step is registered: raise it as the counter reaches the end.
                step_d = tick_d == TICK_LAST;
                eval_d = step_q;
                if (step_q && steps_q != 8'hFF) steps_d = steps_q + 8'd1;
                if (evaluate) begin
                    if (landed && on_target) begin
                        state_d = S_DONE;
                        hit_d   = 1'b1;
                    end else if (landed || off_field || timed_out) begin
                        state_d = (shots_q == SHOT_LIM) ? S_DONE : S_SHOOT;
                        hit_d   = 1'b0;
                    end
                end
                if (state_d != S_ANIMATE) begin
                    tick_d = '0;
                    step_d = 1'b0;
                    eval_d = 1'b0;
                end
            end
            S_DONE: begin
                if (start) state_d = S_INIT;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_INIT;
            tick_q  <= '0;
            step_q  <= 1'b0;
            eval_q  <= 1'b0;
            steps_q <= '0;
            shots_q <= '0;
            hit_q   <= 1'b0;
            vx_q    <= '0;
            vy_q    <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            step_q  <= step_d;
            eval_q  <= eval_d;
            steps_q <= steps_d;
            shots_q <= shots_d;
            hit_q   <= hit_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
        end
    end

    assign q_I        = state_q == S_INIT;
    assign q_P1Shoot  = state_q == S_SHOOT;
    assign q_Animate  = state_q == S_ANIMATE;
    assign q_Done     = state_q == S_DONE;
    assign step       = step_q;
    assign vX_lat     = vx_q;
    assign vY_lat     = vy_q;
    assign hit        = hit_q;
    assign shots_used = shots_q;

endmodule
